// File: rtl/dffsre_pipe_bank.sv
// dffsre_pipe_bank
//   WIDTH-channel, STAGES-deep pipeline of set/reset/enable flops with valid
//   tracking, a pipeline-wide stall, a synchronous preset and a saturating
//   count of accepted fill substitutions.
//
// Ports
//   C          clock, rising edge
//   R          asynchronous active-high reset (clears data, valid, sub_cnt)
//   E          pipeline enable; 0 holds all state
//   S          synchronous preset; wins over E, loads SET_VALUE, clears valid
//   sel        1 = D_in enters stage 0, 0 = FILL_VALUE enters stage 0
//   in_valid   qualifies the word entering stage 0
//   D_in       channel input data
//   Q          last-stage data (registered)
//   out_valid  last-stage valid (registered)
//   sub_cnt    saturating count of valid fill words accepted
module dffsre_pipe_bank #(
  parameter int                 WIDTH      = 10,
  parameter int                 STAGES     = 2,
  parameter logic [WIDTH-1:0]   FILL_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]   SET_VALUE  = {WIDTH{1'b1}},
  parameter int                 CNT_W      = 8
) (
  input  logic              C,
  input  logic              R,
  input  logic              E,
  input  logic              S,
  input  logic              sel,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  D_in,
  output logic [WIDTH-1:0]  Q,
  output logic              out_valid,
  output logic [CNT_W-1:0]  sub_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (S) begin
      // Preset wins over enable: nothing shifts and the counter holds.
      for (int k = 0; k < STAGES; k++) begin
        data_d[k] = SET_VALUE;
      end
      valid_d = '0;
    end else if (E) begin
      data_d[0]  = sel ? D_in : FILL_VALUE;
      valid_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // Only valid fill words count; an unqualified fill still propagates.
      if (in_valid && !sel && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q         = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign sub_cnt   = cnt_q;

endmodule

// File: tb/tb_dffsre_pipe_bank.sv
// Bench for dffsre_pipe_bank (WIDTH=10, STAGES=2, CNT_W=8). A queue-based
// model predicts Q/out_valid/sub_cnt and is compared every cycle; directed
// literal expectations pin the model at key points.
module tb_dffsre_pipe_bank;

  localparam int               WIDTH  = 10;
  localparam int               STAGES = 2;
  localparam int               CNT_W  = 8;
  localparam logic [WIDTH-1:0] FILL   = 10'h3FF;
  localparam logic [WIDTH-1:0] SETV   = 10'h3FF;

  logic              C = 1'b0;
  logic              R;
  logic              E;
  logic              S;
  logic              sel;
  logic              in_valid;
  logic [WIDTH-1:0]  D_in;
  logic [WIDTH-1:0]  Q;
  logic              out_valid;
  logic [CNT_W-1:0]  sub_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  dffsre_pipe_bank #(
    .WIDTH(WIDTH), .STAGES(STAGES), .FILL_VALUE(FILL), .SET_VALUE(SETV), .CNT_W(CNT_W)
  ) dut (
    .C(C), .R(R), .E(E), .S(S), .sel(sel), .in_valid(in_valid), .D_in(D_in),
    .Q(Q), .out_valid(out_valid), .sub_cnt(sub_cnt)
  );

  always #5 C = ~C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each entry is {valid, data}; front = newest word, back = output.
  logic [WIDTH:0] pipe_m[$];
  int             cnt_m;

  always @(posedge C or posedge R) begin
    if (R) begin
      pipe_m.delete();
      for (int i = 0; i < STAGES; i++) pipe_m.push_back({1'b0, {WIDTH{1'b0}}});
      cnt_m = 0;
    end else if (S) begin
      for (int i = 0; i < STAGES; i++) pipe_m[i] = {1'b0, SETV};
    end else if (E) begin
      pipe_m.push_front({in_valid, sel ? D_in : FILL});
      void'(pipe_m.pop_back());
      if (in_valid && !sel && cnt_m < 255) cnt_m = cnt_m + 1;
    end
  end

  always @(negedge C) begin
    if (check_en) begin
      chk("model_q",         {22'd0, Q},         {22'd0, pipe_m[STAGES-1][WIDTH-1:0]});
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, pipe_m[STAGES-1][WIDTH]});
      chk("model_sub_cnt",   {24'd0, sub_cnt},   cnt_m);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge C);
  endtask

  task automatic lit(input string nm, input logic [9:0] q_e, input logic v_e, input logic [7:0] c_e);
    chk({nm, "_q"},   {22'd0, Q},         {22'd0, q_e});
    chk({nm, "_ov"},  {31'd0, out_valid}, {31'd0, v_e});
    chk({nm, "_cnt"}, {24'd0, sub_cnt},   {24'd0, c_e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    R = 1'b1; E = 1'b0; S = 1'b0; sel = 1'b0; in_valid = 1'b0; D_in = '0;
    tick(2);
    lit("reset_hold", 10'h000, 1'b0, 8'd0);
    R = 1'b0;
    check_en = 1'b1;

    // 1. fill with 0x155 valid, then reset mid-cycle
    E = 1'b1; sel = 1'b1; in_valid = 1'b1; D_in = 10'h155;
    tick(2);
    lit("full_155", 10'h155, 1'b1, 8'd0);
    #2 R = 1'b1;
    #1 lit("async_reset", 10'h000, 1'b0, 8'd0);
    tick(1);
    R = 1'b0; E = 1'b0;
    tick(2);
    lit("post_reset_stall", 10'h000, 1'b0, 8'd0);

    // 2. passthrough
    E = 1'b1; sel = 1'b1; in_valid = 1'b1; D_in = 10'h2A5;
    tick(1);
    in_valid = 1'b0; D_in = 10'h000;
    tick(1);
    lit("pass_edge2", 10'h2A5, 1'b1, 8'd0);
    tick(1);
    lit("pass_edge3", 10'h000, 1'b0, 8'd0);

    // 3. fill substitution
    sel = 1'b0; in_valid = 1'b1; D_in = 10'h000;
    tick(2);
    lit("fill_edge2", 10'h3FF, 1'b1, 8'd2);
    tick(1);
    lit("fill_edge3", 10'h3FF, 1'b1, 8'd3);
    in_valid = 1'b0;
    tick(1);
    lit("fill_novalid", 10'h3FF, 1'b1, 8'd3);

    // 4. stall
    sel = 1'b1; in_valid = 1'b1; D_in = 10'h0F0;
    tick(1);
    D_in = 10'h00F;
    tick(1);
    lit("stall_pre", 10'h0F0, 1'b1, 8'd3);
    E = 1'b0; D_in = 10'h155;
    tick(5);
    lit("stall_hold", 10'h0F0, 1'b1, 8'd3);
    E = 1'b1; in_valid = 1'b0; D_in = 10'h000;
    tick(1);
    lit("stall_resume", 10'h00F, 1'b1, 8'd3);
    tick(1);
    lit("stall_drain", 10'h000, 1'b0, 8'd3);

    // 5. set priority
    S = 1'b1; E = 1'b1; sel = 1'b1; in_valid = 1'b1; D_in = 10'h001;
    tick(1);
    lit("set_prio", 10'h3FF, 1'b0, 8'd3);
    S = 1'b0;
    tick(1);
    lit("set_after1", 10'h3FF, 1'b0, 8'd3);
    in_valid = 1'b0;
    tick(1);
    lit("set_after2", 10'h001, 1'b1, 8'd3);
    S = 1'b1; E = 1'b0; sel = 1'b0; in_valid = 1'b1;
    tick(1);
    lit("set_no_enable", 10'h3FF, 1'b0, 8'd3);
    S = 1'b0;

    // 6. saturation
    E = 1'b1; sel = 1'b0; in_valid = 1'b1; D_in = 10'h000;
    tick(300);
    lit("sat_300", 10'h3FF, 1'b1, 8'd255);
    tick(5);
    lit("sat_hold", 10'h3FF, 1'b1, 8'd255);
    #2 R = 1'b1;
    #1 lit("sat_reset", 10'h000, 1'b0, 8'd0);
    tick(1);
    R = 1'b0; E = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
